// File: rtl/rv_pkg.sv
// Shared types and helpers for the RV32IM core memory-side blocks.
package rv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned SRAM_WAIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD,
        ST_RESP
    } sram_state_t;

    // Number of SRAM beats needed to move one core word.
    function automatic int unsigned sram_beats(input int unsigned xlen, input int unsigned w);
        return xlen / w;
    endfunction

endpackage

// File: rtl/rv_sram_ctrl.sv
// Asynchronous-SRAM controller: splits each core word into SRAM beats with
// programmable wait cycles and skips write beats with no enabled lanes.
// Optional macro RV_SRAM_RANGE_ERR_EN adds data_err_o for out-of-range requests.
module rv_sram_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned SRAM_ADDR_WIDTH = 20,
    parameter int unsigned SRAM_DATA_WIDTH = 16,
    parameter int unsigned WAIT_CYCLES     = 1
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         data_req_i,
    output logic                         data_gnt_o,
    input  logic                         data_we_i,
    input  logic [XLEN/8-1:0]            data_be_i,
    input  logic [XLEN-1:0]              data_addr_i,
    input  logic [XLEN-1:0]              data_wdata_i,
    output logic                         data_rvalid_o,
    output logic [XLEN-1:0]              data_rdata_o,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
    output logic                         sram_data_oe,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
`ifdef RV_SRAM_RANGE_ERR_EN
    ,
    output logic                         data_err_o
`endif
);

    localparam int unsigned W        = SRAM_DATA_WIDTH;
    localparam int unsigned LW       = W / 8;
    localparam int unsigned XB       = XLEN / 8;
    localparam int unsigned N        = sram_beats(XLEN, W);
    localparam int unsigned OFF      = $clog2(XB);
    localparam int unsigned BW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW       = SRAM_ADDR_WIDTH;
    localparam int unsigned CAP_BITS = AW + $clog2(LW);

    localparam logic [SRAM_WAIT_W-1:0] WAIT_LAST = SRAM_WAIT_W'(WAIT_CYCLES);
    localparam logic [BW-1:0]          LAST_BEAT = BW'(N - 1);

    // Transaction context
    sram_state_t             state_q, state_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [SRAM_WAIT_W-1:0]  wait_q, wait_d;
    logic                    we_q, we_d;
    logic [XB-1:0]           be_q, be_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [AW-1:0]           base_q, base_d;
    logic [XLEN-1:0]         rbuf_q, rbuf_d;
    logic                    err_q, err_d;

    // Registered outputs
    logic [AW-1:0]           addr_q, addr_d;
    logic [W-1:0]            dout_q, dout_d;
    logic                    doe_q, doe_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [LW-1:0]           be_n_q, be_n_d;
    logic                    rvalid_q, rvalid_d;
    logic [XLEN-1:0]         rdata_q, rdata_d;
    logic                    erro_d;

    logic [XLEN-1:0]         word_idx;
    logic [BW:0]             fb;

    // First beat at or after 'start' whose lane slice has any byte enabled.
    function automatic logic [BW:0] find_beat(input logic [XB-1:0] be, input int unsigned start);
        logic          found;
        logic [BW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && (i >= start) && (|be[i*LW +: LW])) begin
                found = 1'b1;
                idx   = BW'(i);
            end
        end
        return {found, idx};
    endfunction

    assign data_gnt_o = (state_q == ST_IDLE);

    // Next-state, beat/wait counters and read-word assembly.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        base_d   = base_q;
        rbuf_d   = rbuf_q;
        err_d    = err_q;
        word_idx = (data_addr_i >> OFF) * XLEN'(N);
        fb       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    we_d    = data_we_i;
                    be_d    = data_be_i;
                    wdata_d = data_wdata_i;
                    base_d  = AW'(word_idx);
                    rbuf_d  = '0;
                    err_d   = 1'b0;
                    wait_d  = '0;
                    beat_d  = '0;
                    if (data_we_i) begin
                        fb = find_beat(data_be_i, 0);
                        if (fb[BW]) begin
                            state_d = ST_WSETUP;
                            beat_d  = fb[BW-1:0];
                        end else begin
                            state_d = ST_RESP;
                        end
                    end else begin
                        state_d = ST_READ;
                    end
`ifdef RV_SRAM_RANGE_ERR_EN
                    if (|(data_addr_i >> CAP_BITS)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_READ: begin
                if (wait_q == WAIT_LAST) begin
                    rbuf_d[beat_q*W +: W] = sram_data_i;
                    wait_d = '0;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WSETUP: begin
                state_d = ST_WPULSE;
                wait_d  = SRAM_WAIT_W'(1);
            end
            ST_WPULSE: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_WHOLD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WHOLD: begin
                fb = find_beat(be_q, {{(32-BW){1'b0}}, beat_q} + 32'd1);
                if (fb[BW]) begin
                    state_d = ST_WSETUP;
                    beat_d  = fb[BW-1:0];
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so that the registers
    // present each state's bus values during that state's own cycles.
    always_comb begin
        addr_d   = '0;
        dout_d   = '0;
        doe_d    = 1'b0;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        be_n_d   = '1;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        erro_d   = 1'b0;
        unique case (state_d)
            ST_READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
                addr_d = base_d + AW'(beat_d);
            end
            ST_WSETUP, ST_WHOLD: begin
                ce_n_d = 1'b0;
                doe_d  = 1'b1;
                addr_d = base_d + AW'(beat_d);
                dout_d = wdata_d[beat_d*W +: W];
            end
            ST_WPULSE: begin
                ce_n_d = 1'b0;
                doe_d  = 1'b1;
                we_n_d = 1'b0;
                addr_d = base_d + AW'(beat_d);
                dout_d = wdata_d[beat_d*W +: W];
                be_n_d = ~be_d[beat_d*LW +: LW];
            end
            ST_RESP: begin
                rvalid_d = 1'b1;
                rdata_d  = (we_d || err_d) ? '0 : rbuf_d;
                erro_d   = err_d;
            end
            default: begin
            end
        endcase
    end

    // State, context and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            wait_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            base_q   <= '0;
            rbuf_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            doe_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            be_n_q   <= '1;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            base_q   <= base_d;
            rbuf_q   <= rbuf_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            doe_q    <= doe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            be_n_q   <= be_n_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef RV_SRAM_RANGE_ERR_EN
    logic erro_q;

    // Range-error flag, asserted only in the response cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end

    assign data_err_o = erro_q;
`else
    logic unused_erro;
    assign unused_erro = erro_d;
`endif

    assign sram_addr     = addr_q;
    assign sram_data_o   = dout_q;
    assign sram_data_oe  = doe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_rv_sram_ctrl.sv
// Self-checking bench for rv_sram_ctrl: directed vectors, multi-cycle corner
// sequences and randomized traffic against a byte-addressed memory model.
module tb_rv_sram_ctrl;

    logic        clk;
    logic        arst;
    logic        req16, req8;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    // 16-bit SRAM instance signals
    logic        gnt16, rvalid16, doe16, ce16, oe16, we16, err16;
    logic [31:0] rdata16;
    logic [19:0] addr16;
    logic [15:0] din16, dout16;
    logic [1:0]  ben16;

    // 8-bit SRAM instance signals
    logic        gnt8, rvalid8, doe8, ce8, oe8, we8, err8;
    logic [31:0] rdata8;
    logic [19:0] addr8;
    logic [7:0]  din8, dout8;
    logic [0:0]  ben8;

    logic [15:0] mem16 [0:4095];
    logic [7:0]  mem8  [0:4095];
    logic [7:0]  ref_b [0:8191];

    int checks = 0;
    int errors = 0;

    rv_sram_ctrl #(.SRAM_ADDR_WIDTH(20), .SRAM_DATA_WIDTH(16), .WAIT_CYCLES(1)) dut (
        .clk_i(clk), .arst_i(arst), .data_req_i(req16), .data_gnt_o(gnt16),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rvalid_o(rvalid16), .data_rdata_o(rdata16),
        .sram_addr(addr16), .sram_data_i(din16), .sram_data_o(dout16),
        .sram_data_oe(doe16), .sram_ce_n(ce16), .sram_oe_n(oe16), .sram_we_n(we16),
        .sram_be_n(ben16)
`ifdef RV_SRAM_RANGE_ERR_EN
        , .data_err_o(err16)
`endif
    );

    rv_sram_ctrl #(.SRAM_ADDR_WIDTH(20), .SRAM_DATA_WIDTH(8), .WAIT_CYCLES(2)) dut8 (
        .clk_i(clk), .arst_i(arst), .data_req_i(req8), .data_gnt_o(gnt8),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rvalid_o(rvalid8), .data_rdata_o(rdata8),
        .sram_addr(addr8), .sram_data_i(din8), .sram_data_o(dout8),
        .sram_data_oe(doe8), .sram_ce_n(ce8), .sram_oe_n(oe8), .sram_we_n(we8),
        .sram_be_n(ben8)
`ifdef RV_SRAM_RANGE_ERR_EN
        , .data_err_o(err8)
`endif
    );

`ifndef RV_SRAM_RANGE_ERR_EN
    assign err16 = 1'b0;
    assign err8  = 1'b0;
`endif

    assign din16 = mem16[addr16[11:0]];
    assign din8  = mem8[addr8[11:0]];

    // View of whichever instance the current sequence targets
    logic        sel;
    logic        m_gnt, m_rvalid, m_ce, m_we, m_err;
    logic [31:0] m_rdata;
    logic [19:0] m_addr;
    logic [15:0] m_dout;
    logic [1:0]  m_ben;
    assign m_gnt    = sel ? gnt8    : gnt16;
    assign m_rvalid = sel ? rvalid8 : rvalid16;
    assign m_ce     = sel ? ce8     : ce16;
    assign m_we     = sel ? we8     : we16;
    assign m_err    = sel ? err8    : err16;
    assign m_rdata  = sel ? rdata8  : rdata16;
    assign m_addr   = sel ? addr8   : addr16;
    assign m_dout   = sel ? {8'h00, dout8} : dout16;
    assign m_ben    = sel ? {1'b1, ben8}   : ben16;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM write behaviour and bus-protocol monitor
    int viol = 0;
    int pulses = 0;
    always @(negedge clk) begin
        if (!ce16 && !we16) begin
            pulses = pulses + 1;
            for (int l = 0; l < 2; l++)
                if (!ben16[l]) mem16[addr16[11:0]][l*8 +: 8] = dout16[l*8 +: 8];
        end
        if (!ce8 && !we8 && !ben8[0]) mem8[addr8[11:0]] = dout8;
        if (!we16 && (!oe16 || !doe16)) viol = viol + 1;
        if (!oe16 && doe16) viol = viol + 1;
    end

    // Per-cycle trace of the current transaction, index = cycles after accept
    logic [19:0] tr_addr [0:63];
    logic [15:0] tr_dout [0:63];
    logic [1:0]  tr_ben  [0:63];
    logic        tr_we   [0:63];
    logic        tr_ce   [0:63];
    logic        tr_gnt  [0:63];
    logic        tr_err  [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Core-view memory: SRAM byte lanes line up with the core byte address.
    task automatic ref_write(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned b;
        b = {addr[31:2], 2'b00};
        for (int j = 0; j < 4; j++) if (be[j]) ref_b[b + j] = wd[j*8 +: 8];
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int unsigned b;
        b = {addr[31:2], 2'b00};
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic do_txn(input logic s, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd, output int lat);
        int g;
        for (int n = 0; n < 64; n++) begin
            tr_addr[n] = '0; tr_dout[n] = '0; tr_ben[n] = '1;
            tr_we[n] = 1'b1; tr_ce[n] = 1'b1; tr_gnt[n] = 1'b0; tr_err[n] = 1'b0;
        end
        sel = s;
        @(negedge clk);
        data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
        if (s) req8 = 1'b1; else req16 = 1'b1;
        g = 0;
        while (!m_gnt && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            req16 = 1'b0; req8 = 1'b0;
            data_we = 1'($urandom); data_be = 4'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
        end
        lat = -1;
        rd  = '0;
        for (int n = 1; n < 64; n++) begin
            @(negedge clk);
            tr_addr[n] = m_addr; tr_dout[n] = m_dout; tr_ben[n] = m_ben;
            tr_we[n] = m_we; tr_ce[n] = m_ce; tr_gnt[n] = m_gnt; tr_err[n] = m_err;
            if (m_rvalid) begin
                lat = n;
                rd  = m_rdata;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vt [7];
    logic [31:0] rd;
    int          lat;
    int          bad;

    initial begin
        arst = 1'b1; req16 = 1'b0; req8 = 1'b0; sel = 1'b0;
        data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
        for (int i = 0; i < 4096; i++) begin mem16[i] = '0; mem8[i] = '0; end
        for (int i = 0; i < 8192; i++) ref_b[i] = '0;
        mem16[12'h080] = 16'hBEEF; mem16[12'h081] = 16'hDEAD;
        ref_b['h100] = 8'hEF; ref_b['h101] = 8'hBE; ref_b['h102] = 8'hAD; ref_b['h103] = 8'hDE;
        mem8[12'h010] = 8'h11; mem8[12'h011] = 8'h22; mem8[12'h012] = 8'h33; mem8[12'h013] = 8'h44;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(ce16), 32'd1);
        chk("rst_oe_n", 32'(oe16), 32'd1);
        chk("rst_we_n", 32'(we16), 32'd1);
        chk("rst_be_n", 32'(ben16), 32'h3);
        chk("rst_data_oe", 32'(doe16), 32'd0);
        chk("rst_addr", 32'(addr16), 32'd0);
        chk("rst_dout", 32'(dout16), 32'd0);
        chk("rst_rvalid", 32'(rvalid16), 32'd0);
        chk("rst_rdata", rdata16, 32'd0);
        chk("rst_err", 32'(err16), 32'd0);
        arst = 1'b0;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt16), 32'd1);

        // Full-word write: two beats
        do_txn(1'b0, 1'b1, 4'hF, 32'h8, 32'h12345678, 1'b0, rd, lat);
        ref_write(4'hF, 32'h8, 32'h12345678);
        chk("t2_lat", 32'(lat), 32'd7);
        chk("t2_setup_we_n", 32'(tr_we[1]), 32'd1);
        chk("t2_setup_addr", 32'(tr_addr[1]), 32'h4);
        chk("t2_b0_we_n", 32'(tr_we[2]), 32'd0);
        chk("t2_b0_addr", 32'(tr_addr[2]), 32'h4);
        chk("t2_b0_data", 32'(tr_dout[2]), 32'h5678);
        chk("t2_b0_be_n", 32'(tr_ben[2]), 32'h0);
        chk("t2_hold_we_n", 32'(tr_we[3]), 32'd1);
        chk("t2_hold_addr", 32'(tr_addr[3]), 32'h4);
        chk("t2_b1_we_n", 32'(tr_we[5]), 32'd0);
        chk("t2_b1_addr", 32'(tr_addr[5]), 32'h5);
        chk("t2_b1_data", 32'(tr_dout[5]), 32'h1234);
        chk("t2_rdata", rd, 32'd0);

        // Single-lane write: beat 0 skipped
        do_txn(1'b0, 1'b1, 4'b0100, 32'h0, 32'h00AB0000, 1'b0, rd, lat);
        ref_write(4'b0100, 32'h0, 32'h00AB0000);
        chk("t3_lat", 32'(lat), 32'd4);
        chk("t3_addr", 32'(tr_addr[2]), 32'h1);
        chk("t3_data", 32'(tr_dout[2]), 32'h00AB);
        chk("t3_be_n", 32'(tr_ben[2]), 32'h2);
        chk("t3_we_n", 32'(tr_we[2]), 32'd0);
        bad = 0;
        for (int n = 1; n <= 4; n++) if (!tr_we[n] && tr_addr[n] == 20'h0) bad++;
        chk("t3_no_addr0_pulse", 32'(bad), 32'd0);

        // Empty write with request held: re-granted two cycles after accept
        do_txn(1'b0, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 1'b1, rd, lat);
        chk("t4_lat", 32'(lat), 32'd1);
        chk("t4_ce_n", 32'(tr_ce[1]), 32'd1);
        chk("t4_we_n", 32'(tr_we[1]), 32'd1);
        chk("t4_gnt_resp", 32'(tr_gnt[1]), 32'd0);
        @(negedge clk);
        chk("t4_regrant", 32'(gnt16), 32'd1);
        @(negedge clk);
        chk("t4_second_rvalid", 32'(rvalid16), 32'd1);
        req16 = 1'b0;

        // Reset during the write pulse of beat 0
        sel = 1'b0;
        @(negedge clk);
        data_we = 1'b1; data_be = 4'hF; data_addr = 32'h800; data_wdata = 32'hA5A5A5A5;
        req16 = 1'b1;
        bad = 0;
        while (!gnt16 && bad < 50) begin @(negedge clk); bad++; end
        @(posedge clk);
        #1 req16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_pulse", 32'(we16), 32'd0);
        #1 arst = 1'b1;
        #1;
        chk("t5_async_we_n", 32'(we16), 32'd1);
        chk("t5_async_ce_n", 32'(ce16), 32'd1);
        chk("t5_async_be_n", 32'(ben16), 32'h3);
        bad = 0;
        for (int n = 0; n < 4; n++) begin @(negedge clk); if (rvalid16) bad++; end
        arst = 1'b0;
        for (int n = 0; n < 10; n++) begin @(negedge clk); if (rvalid16) bad++; end
        chk("t5_no_rvalid", 32'(bad), 32'd0);

        // Directed vector table
        vt[0] = '{1'b0, 4'hF,    32'h100, 32'h0,        32'hDEADBEEF, 5};
        vt[1] = '{1'b0, 4'hF,    32'h008, 32'h0,        32'h12345678, 5};
        vt[2] = '{1'b0, 4'hF,    32'h000, 32'h0,        32'h00AB0000, 5};
        vt[3] = '{1'b1, 4'b0011, 32'h020, 32'hCAFEF00D, 32'h0,        4};
        vt[4] = '{1'b0, 4'h0,    32'h020, 32'h0,        32'h0000F00D, 5};
        vt[5] = '{1'b1, 4'b1000, 32'h020, 32'h99000000, 32'h0,        4};
        vt[6] = '{1'b0, 4'h5,    32'h022, 32'h0,        32'h9900F00D, 5};
        for (int i = 0; i < 7; i++) begin
            do_txn(1'b0, vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, 1'b0, rd, lat);
            if (vt[i].we) ref_write(vt[i].be, vt[i].addr, vt[i].wdata);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
        end

        // 8-bit SRAM, two wait cycles
        do_txn(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, rd, lat);
        chk("t6_lat", 32'(lat), 32'd13);
        chk("t6_rdata", rd, 32'h44332211);
        for (int n = 1; n <= 12; n++) begin
            chk($sformatf("t6_addr_T%0d", n), 32'(tr_addr[n]), 32'h10 + 32'((n - 1) / 3));
            chk($sformatf("t6_ce_T%0d", n), 32'(tr_ce[n]), 32'd0);
        end
        sel = 1'b0;

`ifdef RV_SRAM_RANGE_ERR_EN
        do_txn(1'b0, 1'b0, 4'hF, 32'h0020_0000, 32'h0, 1'b0, rd, lat);
        chk("t6e_lat", 32'(lat), 32'd1);
        chk("t6e_err", 32'(tr_err[1]), 32'd1);
        chk("t6e_ce_n", 32'(tr_ce[1]), 32'd1);
        chk("t6e_rdata", rd, 32'd0);
        do_txn(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, rd, lat);
        chk("t6e_inrange_err", 32'(tr_err[lat > 0 ? lat : 1]), 32'd0);
`endif

        // Randomized traffic against the byte-addressed model
        begin
            int p0, exp_p, b_cnt, exp_lat;
            logic        r_we;
            logic [3:0]  r_be;
            logic [31:0] r_addr, r_wd, exp_rd;
            p0 = pulses;
            exp_p = 0;
            for (int i = 0; i < 150; i++) begin
                r_we   = 1'($urandom_range(0, 1));
                r_be   = 4'($urandom);
                r_addr = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
                r_wd   = $urandom;
                b_cnt  = ((r_be[1:0] != 2'b00) ? 1 : 0) + ((r_be[3:2] != 2'b00) ? 1 : 0);
                if (r_we) begin
                    exp_lat = b_cnt * 3 + 1;
                    exp_rd  = '0;
                    exp_p   = exp_p + b_cnt;
                end else begin
                    exp_lat = 5;
                    exp_rd  = ref_read(r_addr);
                end
                do_txn(1'b0, r_we, r_be, r_addr, r_wd, 1'b0, rd, lat);
                if (r_we) ref_write(r_be, r_addr, r_wd);
                chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
            end
            chk("rnd_pulse_cycles", 32'(pulses - p0), 32'(exp_p));
        end
        chk("bus_protocol_violations", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
